// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - multi-lane decode queue with branch pre-classification and delay-slot tagging
//
// Purpose: circular buffer between fetch and rename/issue. Accepts up to
// FETCH_WIDTH words per cycle, tags branches/jumps and their delay slots, and
// presents up to ISSUE_WIDTH in-order entries without splitting a branch from
// its delay slot.
//
// Ports:
//   clk, resetn (sync, active-low), flush
//   in_valid/in_instr/in_pc   : fetch group, lane 0 oldest, in_valid is a prefix
//   in_ready                  : a full FETCH_WIDTH group fits this cycle
//   out_valid/out_instr/out_pcplus4/out_is_branch/out_in_delay_slot : issue window
//   out_accept                : number of leading out lanes consumed
module decode_queue #(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               flush,
  input  logic [FETCH_WIDTH-1:0]             in_valid,
  input  logic [FETCH_WIDTH*32-1:0]          in_instr,
  input  logic [FETCH_WIDTH*32-1:0]          in_pc,
  output logic                               in_ready,
  output logic [ISSUE_WIDTH-1:0]             out_valid,
  output logic [ISSUE_WIDTH*32-1:0]          out_instr,
  output logic [ISSUE_WIDTH*32-1:0]          out_pcplus4,
  output logic [ISSUE_WIDTH-1:0]             out_is_branch,
  output logic [ISSUE_WIDTH-1:0]             out_in_delay_slot,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   out_accept
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      pc4_q   [DEPTH];
  logic [DEPTH-1:0] br_q;
  logic [DEPTH-1:0] ds_q;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          lwb_q, lwb_d;

  logic [FETCH_WIDTH-1:0] lane_br;
  logic [FETCH_WIDTH-1:0] lane_ds;
  logic [CW-1:0]          push_cnt;

  function automatic logic classify_branch(input logic [31:0] w);
    logic r;
    r = 1'b0;
    case (w[31:26])
      6'b000100, 6'b000101, 6'b000001, 6'b000110,
      6'b000111, 6'b000010, 6'b000011: r = 1'b1;
      6'b000000: r = (w[5:0] == 6'b001000) || (w[5:0] == 6'b001001);
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  // Depends on registered count only, so a pop in the same cycle cannot
  // reopen a full queue.
  assign in_ready = (count_q <= CW'(DEPTH - FETCH_WIDTH));

  // Enqueue side: classification and delay-slot chaining across lanes.
  // 'prev' walks the valid prefix so the last valid lane's branch flag
  // carries into the next push via last_was_branch.
  always_comb begin
    logic prev;
    lane_br  = '0;
    lane_ds  = '0;
    push_cnt = '0;
    prev     = lwb_q;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_br[i] = classify_branch(in_instr[i*32 +: 32]);
      lane_ds[i] = prev;
      if (in_valid[i]) begin
        prev     = lane_br[i];
        push_cnt = push_cnt + CW'(1);
      end
    end
    lwb_d   = in_ready ? prev : lwb_q;
    tail_d  = in_ready ? tail_q + PW'(push_cnt) : tail_q;
    head_d  = head_q + PW'(out_accept);
    count_d = count_q + (in_ready ? push_cnt : '0) - CW'(out_accept);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      lwb_q   <= 1'b0;
      br_q    <= '0;
      ds_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc4_q[i]   <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      lwb_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      lwb_q   <= lwb_d;
      if (in_ready) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
          if (in_valid[i]) begin
            instr_q[tail_q + PW'(i)] <= in_instr[i*32 +: 32];
            pc4_q[tail_q + PW'(i)]   <= in_pc[i*32 +: 32] + 32'd4;
            br_q[tail_q + PW'(i)]    <= lane_br[i];
            ds_q[tail_q + PW'(i)]    <= lane_ds[i];
          end
        end
      end
    end
  end

  // Issue window: stop at the first non-candidate lane, or at a branch whose
  // delay slot is not in the same window (last lane or not yet enqueued).
  always_comb begin
    logic          stop;
    logic          cand_i;
    logic          cand_n;
    logic [PW-1:0] rd_idx;
    out_valid         = '0;
    out_instr         = '0;
    out_pcplus4       = '0;
    out_is_branch     = '0;
    out_in_delay_slot = '0;
    stop   = 1'b0;
    cand_i = 1'b0;
    cand_n = 1'b0;
    rd_idx = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      rd_idx = head_q + PW'(i);
      cand_i = (count_q > CW'(i));
      cand_n = (i + 1 < ISSUE_WIDTH) && (count_q > CW'(i + 1));
      if (!cand_i || (br_q[rd_idx] && !cand_n)) stop = 1'b1;
      if (!stop) begin
        out_valid[i]            = 1'b1;
        out_instr[i*32 +: 32]   = instr_q[rd_idx];
        out_pcplus4[i*32 +: 32] = pc4_q[rd_idx];
        out_is_branch[i]        = br_q[rd_idx];
        out_in_delay_slot[i]    = ds_q[rd_idx];
      end
    end
  end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised multi-lane decode queue between fetch and rename/issue. Accepts up to FETCH_WIDTH instruction words per cycle into a circular buffer and pre-classifies each as branch/jump. Tags delay-slot instructions, including when the branch and its slot arrive in different cycles. Presents up to ISSUE_WIDTH in-order entries per cycle and never splits a branch from its delay slot across issue groups.

## Interface
Parameters:
- FETCH_WIDTH, 2, instructions offered per cycle (≥1).
- ISSUE_WIDTH, 2, max entries presented per cycle (≥2).
- DEPTH, 8, queue entries; power of two, ≥ FETCH_WIDTH + ISSUE_WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset; synchronous, active-low.
- flush  in  1  discard all contents (branch mispredict / exception).
- in_valid  in  FETCH_WIDTH  per-lane valid; must be a prefix (lane i valid ⇒ lanes <i valid).
- in_instr  in  FETCH_WIDTH×32  instruction words, lane 0 oldest.
- in_pc  in  FETCH_WIDTH×32  PC of each lane.
- in_ready  out  1  queue can accept a full FETCH_WIDTH group this cycle.
- out_valid  out  ISSUE_WIDTH  per-lane valid; always a prefix.
- out_instr  out  ISSUE_WIDTH×32  instruction word, lane 0 oldest.
- out_pcplus4  out  ISSUE_WIDTH×32  PC+4 of entry.
- out_is_branch  out  ISSUE_WIDTH  entry is branch/jump.
- out_in_delay_slot  out  ISSUE_WIDTH  entry is in a delay slot.
- out_accept  in  clog2(ISSUE_WIDTH+1)  number of leading lanes consumed; must be ≤ popcount(out_valid).

## Operation
- Storage: DEPTH entries {instr, pcplus4, is_branch, in_delay_slot}; head/tail pointers of clog2(DEPTH) bits, wrap mod DEPTH; count register of clog2(DEPTH)+1 bits.
- Branch classification (combinational on enqueue): op ∈ {BEQ 000100, BNE 000101, REGIMM 000001, BLEZ 000110, BGTZ 000111, J 000010, JAL 000011}, or op=000000 with func ∈ {JR 001000, JALR 001001}. Anything else: is_branch=0.
- Delay-slot tag: an entry gets in_delay_slot=1 iff the instruction enqueued immediately before it (earlier lane in the same group, or the last lane of the most recent prior push) is a branch. Register last_was_branch carries this across cycles.
- Push: when in_ready=1, all in_valid lanes are written at tail; tail += popcount(in_valid). When in_ready=0, inputs are ignored and fetch holds them.
- Pop: head += out_accept; count' = count + pushed − out_accept; simultaneous push and pop are legal in the same cycle.
- Issue window: candidate lane i valid iff count > i. out_valid is the candidate prefix truncated just before the first lane i whose entry is a branch and whose lane i+1 is not a candidate (branch at the last lane, or slot not yet enqueued). A branch is therefore only presented together with its delay slot.
- Flush: head=tail=count=0, last_was_branch=0; overrides push and pop in the same cycle.
- Reset (resetn=0 at edge): same as flush, plus storage cleared to 0.

## Timing
- in_ready = (DEPTH − count ≥ FETCH_WIDTH); function of registered count only, no combinational path from in_valid/out_accept.
- out_* are functions of registered state only; enqueue-to-visible latency is 1 cycle; accepted entries disappear the next cycle.
- Throughput: FETCH_WIDTH in, ISSUE_WIDTH out per cycle sustained.
- After the reset edge: out_valid=0, out data 0, in_ready=1, count=0.
- Full: count > DEPTH − FETCH_WIDTH ⇒ in_ready=0, even if out_accept>0 in that cycle.
- Wrap-around: tail/head crossing DEPTH−1→0 preserves order and tags.
- flush or reset mid-operation: the next cycle shows out_valid=0 and in_ready=1; the next pushed instruction is never tagged delay-slot.

## Test plan
- Reset then push {ADDU, BEQ} (FETCH_WIDTH=2): next cycle out_valid=01, lane 0=ADDU; BEQ held. Push {NOP}: out_valid=11 after accept 1, lanes BEQ(is_branch=1), NOP(in_delay_slot=1).
- Push {J, ADDU} same cycle: out_valid=11, out_is_branch=01, out_in_delay_slot=10, out_pcplus4 = in_pc+4 per lane.
- Fill with out_accept=0: after 4 pushes of 2 (DEPTH=8) in_ready=0; then a 5th group offered is ignored; accept 2 → in_ready=1 next cycle; order preserved.
- Wrap: 20 cycles of push 2 / accept 2 with PC increments of 4: output PCs strictly sequential across pointer wrap, no drops or duplicates.
- Push {ADDU, JR} then flush in the next cycle with a push {ADDI}: queue empty after flush; next push {ADDI} shows in_delay_slot=0.
- Simultaneous push 2 / accept 1 at count=6: count becomes 7, in_ready=0.
